sysid_verifier: RTL and testbench

Boot-time and on-demand checker for the system-ID slave. It drives the slave's one-bit address, reads the ID word (address 0) and the timestamp word (address 1), and compares both against build-time expected values. It retries a bounded number of times on mismatch and then publishes sticky pass/fail flags. It sits beside the system-ID slave in the Nios control subsystem, and its flags gate the camera path enable in software.

---
 rtl/sysid_pkg.sv | 27 ++
 rtl/sysid_word_reader.sv | 41 ++++
 rtl/sysid_verifier.sv | 186 ++++++++++++++++++
 tb/tb_sysid_verifier.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID checker and the system-ID slave wrapper.
package sysid_pkg;

  // Check sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE_ID = 3'd1,
    ST_WAIT_ID  = 3'd2,
    ST_ISSUE_TS = 3'd3,
    ST_WAIT_TS  = 3'd4,
    ST_COMPARE  = 3'd5,
    ST_DONE     = 3'd6
  } sysid_state_t;

  // Slave register map: address 0 holds the ID, address 1 the build timestamp.
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // One slave data word.
  typedef logic [31:0] sysid_word_t;

  // Full-width equality; no bits are masked out.
  function automatic logic word_match(input sysid_word_t a, input sysid_word_t b);
    return (a == b);
  endfunction

endpackage

// File: rtl/sysid_word_reader.sv
// Single-word read engine: latches an address, waits READ_LATENCY edges and
// flags the edge on which the slave's readdata must be captured.
module sysid_word_reader
  import sysid_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        issue,
  input  logic        issue_addr,
  input  sysid_word_t sys_readdata,
  output logic        sys_address,
  output sysid_word_t word,
  output logic        word_valid
);

  localparam logic [3:0] LAT = 4'(READ_LATENCY);

  logic [3:0] count;

  // Address register (held between reads) and latency countdown.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sys_address <= 1'b0;
      count       <= 4'd0;
    end else if (issue) begin
      sys_address <= issue_addr;
      count       <= LAT;
    end else if (count != 4'd0) begin
      count       <= count - 4'd1;
    end else begin
      count       <= 4'd0;
    end
  end

  // The capture edge is the one on which the countdown sits at 1.
  assign word_valid = (count == 4'd1);
  assign word       = sys_readdata;

endmodule

// File: rtl/sysid_verifier.sv
// Boot-time / on-demand checker of the system-ID slave: reads ID and timestamp,
// compares them with build-time values, retries on mismatch, publishes sticky flags.
module sysid_verifier
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID  = 32'd0,
  parameter logic [31:0] EXPECTED_TS  = 32'd1370140082,
  parameter int          READ_LATENCY = 1,
  parameter int          RETRY_MAX    = 3,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        sys_address,
  input  sysid_word_t sys_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        mismatch,
  output sysid_word_t id_value,
  output sysid_word_t ts_value,
  output logic [3:0]  retry_count
);

  localparam logic [3:0] RETRY_LIM = 4'(RETRY_MAX);

  sysid_state_t state;
  sysid_state_t next_state;

  logic        auto_pending;
  logic        issue;
  logic        issue_addr;
  logic        word_valid;
  sysid_word_t word;
  logic        begin_check;
  logic        cap_id;
  logic        cap_ts;
  logic        compare_en;
  logic        retry_inc;
  logic        set_mismatch;
  logic        id_match;
  logic        ts_match;

  assign id_match = word_match(id_value, EXPECTED_ID);
  assign ts_match = word_match(ts_value, EXPECTED_TS);

  sysid_word_reader #(
    .READ_LATENCY (READ_LATENCY)
  ) u_reader (
    .clock        (clock),
    .reset_n      (reset_n),
    .issue        (issue),
    .issue_addr   (issue_addr),
    .sys_readdata (sys_readdata),
    .sys_address  (sys_address),
    .word         (word),
    .word_valid   (word_valid)
  );

  // One-shot request that fires on the first edge after reset release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      auto_pending <= AUTO_START;
    end else begin
      auto_pending <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and per-state control strobes.
  always_comb begin
    next_state   = state;
    issue        = 1'b0;
    issue_addr   = SYSID_ADDR_ID;
    begin_check  = 1'b0;
    cap_id       = 1'b0;
    cap_ts       = 1'b0;
    compare_en   = 1'b0;
    retry_inc    = 1'b0;
    set_mismatch = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start || auto_pending) begin
          begin_check = 1'b1;
          next_state  = ST_ISSUE_ID;
        end else begin
          next_state  = ST_IDLE;
        end
      end
      ST_ISSUE_ID: begin
        issue      = 1'b1;
        issue_addr = SYSID_ADDR_ID;
        next_state = ST_WAIT_ID;
      end
      ST_WAIT_ID: begin
        if (word_valid) begin
          cap_id     = 1'b1;
          next_state = ST_ISSUE_TS;
        end else begin
          next_state = ST_WAIT_ID;
        end
      end
      ST_ISSUE_TS: begin
        issue      = 1'b1;
        issue_addr = SYSID_ADDR_TS;
        next_state = ST_WAIT_TS;
      end
      ST_WAIT_TS: begin
        if (word_valid) begin
          cap_ts     = 1'b1;
          next_state = ST_COMPARE;
        end else begin
          next_state = ST_WAIT_TS;
        end
      end
      ST_COMPARE: begin
        compare_en = 1'b1;
        if (id_match && ts_match) begin
          next_state = ST_DONE;
        end else if (retry_count < RETRY_LIM) begin
          retry_inc  = 1'b1;
          next_state = ST_ISSUE_ID;
        end else begin
          set_mismatch = 1'b1;
          next_state   = ST_DONE;
        end
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Registered status outputs, captured words and sticky result flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      mismatch    <= 1'b0;
      id_value    <= 32'd0;
      ts_value    <= 32'd0;
      retry_count <= 4'd0;
    end else begin
      busy <= (state != ST_IDLE);
      done <= (state == ST_DONE);
      if (begin_check) begin
        id_ok       <= 1'b0;
        ts_ok       <= 1'b0;
        mismatch    <= 1'b0;
        retry_count <= 4'd0;
      end
      if (cap_id) begin
        id_value <= word;
      end
      if (cap_ts) begin
        ts_value <= word;
      end
      if (compare_en) begin
        id_ok <= id_match;
        ts_ok <= ts_match;
      end
      if (retry_inc) begin
        retry_count <= retry_count + 4'd1;
      end
      if (set_mismatch) begin
        mismatch <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sysid_verifier.sv
// Self-checking bench for sysid_verifier: directed table, randomized passes
// against a pass-level model, start/reset corner sequences, and a latency-3 instance.
`timescale 1ns/1ps
module tb_sysid_verifier;

  localparam logic [31:0] GOOD_TS = 32'd1370140082;
  localparam logic [31:0] BAD_TS  = 32'd1370140081;
  localparam int          L1      = 1;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n;
  logic start1, start2;

  // DUT1: L=1, AUTO_START=1, RETRY_MAX=3
  logic        addr1, busy1, done1, idok1, tsok1, mis1;
  logic [31:0] rd1, idv1, tsv1;
  logic [3:0]  retry1;
  // DUT2: L=3, AUTO_START=0, RETRY_MAX=1
  logic        addr2, busy2, done2, idok2, tsok2, mis2;
  logic [31:0] rd2, idv2, tsv2;
  logic [3:0]  retry2;

  // Slave model for DUT1: ID word fixed per check, timestamp word chosen per pass.
  // A pass is recognised by the address rising to 1.
  logic [31:0]      id_word;
  logic [3:0][31:0] ts_seq;
  int               rise1 = 0;
  int               base1 = 0;
  logic [1:0]       idx1;

  always @(posedge addr1) rise1 = rise1 + 1;
  assign idx1 = 2'(rise1 - base1 - 1);
  assign rd1  = addr1 ? ts_seq[idx1] : id_word;
  assign rd2  = addr2 ? GOOD_TS : 32'd0;

  sysid_verifier #(
    .READ_LATENCY (1), .RETRY_MAX (3), .AUTO_START (1'b1)
  ) dut1 (
    .clock (clock), .reset_n (reset_n), .start (start1),
    .sys_address (addr1), .sys_readdata (rd1),
    .busy (busy1), .done (done1), .id_ok (idok1), .ts_ok (tsok1),
    .mismatch (mis1), .id_value (idv1), .ts_value (tsv1), .retry_count (retry1)
  );

  sysid_verifier #(
    .READ_LATENCY (3), .RETRY_MAX (1), .AUTO_START (1'b0)
  ) dut2 (
    .clock (clock), .reset_n (reset_n), .start (start2),
    .sys_address (addr2), .sys_readdata (rd2),
    .busy (busy2), .done (done2), .id_ok (idok2), .ts_ok (tsok2),
    .mismatch (mis2), .id_value (idv2), .ts_value (tsv2), .retry_count (retry2)
  );

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0]      idw;
    logic [3:0][31:0] ts;
    logic             e_id_ok;
    logic             e_ts_ok;
    logic             e_mis;
    logic [3:0]       e_retry;
    int               e_done;
    logic [31:0]      e_tsv;
  } vec_t;

  vec_t tbl[6];

  // Pass-level reference: each pass reads (idw, ts[p]); stop on full match or after 4 passes.
  function automatic vec_t model(input logic [31:0] idw, input logic [3:0][31:0] ts);
    vec_t v;
    int   passes;
    logic iok, tok;
    v.idw = idw;
    v.ts  = ts;
    passes = 0;
    iok = 1'b0;
    tok = 1'b0;
    for (int p = 0; p < 4; p++) begin
      iok    = (idw == 32'd0);
      tok    = (ts[p] == GOOD_TS);
      passes = p + 1;
      if (iok && tok) break;
    end
    v.e_id_ok = iok;
    v.e_ts_ok = tok;
    v.e_mis   = !(iok && tok);
    v.e_retry = 4'(passes - 1);
    v.e_done  = passes * (2 * L1 + 3) + 1;
    v.e_tsv   = ts[passes - 1];
    return v;
  endfunction

  // Runs one DUT1 check. With via_start=0 the caller has just released reset
  // on a falling edge, so the next rising edge is edge 0 (auto-start).
  task automatic run1(input vec_t v, input bit via_start, input int pulse_k, input string tag);
    int got;
    int ndone;
    bit busy_err;
    id_word = v.idw;
    ts_seq  = v.ts;
    base1   = rise1;
    if (via_start) begin
      @(negedge clock);
      start1 = 1'b1;
    end
    got = -1;
    ndone = 0;
    busy_err = 1'b0;
    for (int k = 0; k <= v.e_done + 4; k++) begin
      @(negedge clock);
      start1 = (k == pulse_k);
      if (done1) begin
        ndone = ndone + 1;
        if (got < 0) got = k;
      end
      if (busy1 !== ((k >= 1) && (k <= v.e_done))) busy_err = 1'b1;
    end
    check({tag, " done_edge"}, 64'(got), 64'(v.e_done));
    check({tag, " done_count"}, 64'(ndone), 64'd1);
    check({tag, " busy_window_err"}, 64'(busy_err), 64'd0);
    check({tag, " flags"}, {61'd0, idok1, tsok1, mis1}, {61'd0, v.e_id_ok, v.e_ts_ok, v.e_mis});
    check({tag, " retry_count"}, 64'(retry1), 64'(v.e_retry));
    check({tag, " id_value"}, 64'(idv1), 64'(v.idw));
    check({tag, " ts_value"}, 64'(tsv1), 64'(v.e_tsv));
  endtask

  // Runs one DUT2 check and records sys_address after each edge.
  task automatic run2(output logic [15:0] addrs, output int got);
    addrs = 16'd0;
    got = -1;
    @(negedge clock);
    start2 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      start2 = 1'b0;
      addrs[k] = addr2;
      if (done2 && got < 0) got = k;
    end
  endtask

  initial begin
    vec_t        v;
    logic [3:0][31:0] ts;
    logic [31:0] idw;
    logic [15:0] addrs;
    int          got;
    int          ndone;
    int          first_k;
    int          second_k;

    reset_n = 1'b0;
    start1  = 1'b0;
    start2  = 1'b0;
    id_word = 32'd0;
    ts_seq  = {GOOD_TS, GOOD_TS, GOOD_TS, GOOD_TS};

    // Directed table: hand-derived expectations (L=1, pass = 5 edges).
    tbl[0].idw = 32'd0; tbl[0].ts = {GOOD_TS, GOOD_TS, GOOD_TS, GOOD_TS};
    tbl[0].e_id_ok = 1'b1; tbl[0].e_ts_ok = 1'b1; tbl[0].e_mis = 1'b0;
    tbl[0].e_retry = 4'd0; tbl[0].e_done = 6;  tbl[0].e_tsv = GOOD_TS;
    tbl[1].idw = 32'd0; tbl[1].ts = {BAD_TS, BAD_TS, BAD_TS, BAD_TS};
    tbl[1].e_id_ok = 1'b1; tbl[1].e_ts_ok = 1'b0; tbl[1].e_mis = 1'b1;
    tbl[1].e_retry = 4'd3; tbl[1].e_done = 21; tbl[1].e_tsv = BAD_TS;
    tbl[2].idw = 32'd0; tbl[2].ts = {GOOD_TS, GOOD_TS, GOOD_TS, BAD_TS};
    tbl[2].e_id_ok = 1'b1; tbl[2].e_ts_ok = 1'b1; tbl[2].e_mis = 1'b0;
    tbl[2].e_retry = 4'd1; tbl[2].e_done = 11; tbl[2].e_tsv = GOOD_TS;
    tbl[3].idw = 32'd1; tbl[3].ts = {GOOD_TS, GOOD_TS, GOOD_TS, GOOD_TS};
    tbl[3].e_id_ok = 1'b0; tbl[3].e_ts_ok = 1'b1; tbl[3].e_mis = 1'b1;
    tbl[3].e_retry = 4'd3; tbl[3].e_done = 21; tbl[3].e_tsv = GOOD_TS;
    tbl[4].idw = 32'd0; tbl[4].ts = {GOOD_TS, BAD_TS, BAD_TS, BAD_TS};
    tbl[4].e_id_ok = 1'b1; tbl[4].e_ts_ok = 1'b1; tbl[4].e_mis = 1'b0;
    tbl[4].e_retry = 4'd3; tbl[4].e_done = 21; tbl[4].e_tsv = GOOD_TS;
    tbl[5].idw = 32'd0;
    tbl[5].ts = {GOOD_TS ^ 32'h8000_0000, GOOD_TS ^ 32'h8000_0000,
                 GOOD_TS ^ 32'h8000_0000, GOOD_TS ^ 32'h8000_0000};
    tbl[5].e_id_ok = 1'b1; tbl[5].e_ts_ok = 1'b0; tbl[5].e_mis = 1'b1;
    tbl[5].e_retry = 4'd3; tbl[5].e_done = 21; tbl[5].e_tsv = GOOD_TS ^ 32'h8000_0000;

    // Reset state with the clock running.
    repeat (3) @(negedge clock);
    check("reset_flags", {57'd0, addr1, busy1, done1, idok1, tsok1, mis1, retry1[0]},
          64'd0);
    check("reset_values", {idv1, tsv1}, 64'd0);
    check("reset_retry", 64'(retry1), 64'd0);

    // Auto-start after reset release.
    @(negedge clock);
    reset_n = 1'b1;
    run1(tbl[0], 1'b0, -1, "auto");
    check("dut2_no_autostart", {62'd0, busy2, done2}, 64'd0);

    // Directed table via start; the last entry also pulses start mid-check.
    for (int i = 0; i < 6; i++) begin
      run1(tbl[i], 1'b1, (i == 5) ? 3 : -1, $sformatf("tbl%0d", i));
    end

    // Randomized passes against the pass-level model.
    for (int r = 0; r < 10; r++) begin
      idw = ($urandom_range(0, 3) == 0) ? ($urandom | 32'd1) : 32'd0;
      for (int p = 0; p < 4; p++) begin
        ts[p] = ($urandom_range(0, 1) == 1) ? GOOD_TS : $urandom;
      end
      v = model(idw, ts);
      run1(v, 1'b1, -1, $sformatf("rand%0d", r));
    end

    // start held high: second check begins only after the first ends.
    id_word = 32'd0;
    ts_seq  = {GOOD_TS, GOOD_TS, GOOD_TS, GOOD_TS};
    base1   = rise1;
    @(negedge clock);
    start1 = 1'b1;
    ndone = 0;
    first_k = -1;
    second_k = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (k == 13) start1 = 1'b0;
      if (done1) begin
        ndone = ndone + 1;
        if (first_k < 0) first_k = k;
        else if (second_k < 0) second_k = k;
      end
    end
    check("held_done_count", 64'(ndone), 64'd2);
    check("held_first_done", 64'(first_k), 64'd6);
    check("held_second_done", 64'(second_k), 64'd13);

    // Latency-3 instance: address timing and done edge 2L+4 = 10.
    run2(addrs, got);
    check("l3_run1_addr", 64'(addrs[5:0]), 64'b100000);
    check("l3_run1_done", 64'(got), 64'd10);
    run2(addrs, got);
    check("l3_run2_addr", 64'(addrs[5:0]), 64'b100001);
    check("l3_run2_done", 64'(got), 64'd10);
    check("l3_flags", {60'd0, idok2, tsok2, mis2, busy2}, 64'b1100);
    check("l3_values", {idv2, tsv2}, {32'd0, GOOD_TS});

    // Reset during WAIT_TS aborts asynchronously, then auto-start reruns cleanly.
    id_word = 32'd0;
    ts_seq  = {GOOD_TS, GOOD_TS, GOOD_TS, GOOD_TS};
    base1   = rise1;
    @(negedge clock);
    start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    repeat (3) @(negedge clock);
    check("pre_reset_busy_addr", {62'd0, busy1, addr1}, 64'b11);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_flags", {57'd0, addr1, busy1, done1, idok1, tsok1, mis1, retry1[0]},
          64'd0);
    check("async_reset_values", {idv1, tsv1}, 64'd0);
    check("async_reset_retry", 64'(retry1), 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    run1(tbl[0], 1'b0, -1, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
